des_key_schedule_ctrl: RTL and testbench

- Sequences the DES key schedule for the round datapath.
- Accepts a 64-bit key and passes it through an internal permuted_choice_1 instance.
- Then steps the 28-bit C/D halves through 16 rounds of rotations: left for encrypt, right for decrypt.
- Presents one round's C/D pair per handshake to the round pipeline. PC-2 compression is downstream.

---
 rtl/des_key_schedule_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_des_key_schedule_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule_ctrl.sv
// -----------------------------------------------------------------------------
// des_key_schedule_ctrl
//
// Sequences the DES key schedule for a downstream round pipeline. A 64-bit key
// goes through PC-1. The resulting 28-bit C/D halves are then rotated through
// 16 rounds. One round's C/D pair is presented per valid/ready handshake.
// PC-2 compression happens downstream and is not part of this block.
//
// Bit numbering: index 0 of every vector is DES bit 1.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   rst          in   1   synchronous, active-high reset
//   key_in       in   64  key, key_in[i] = DES key bit i+1
//   key_valid    in   1   key_in/decrypt valid
//   key_ready    out  1   high only in IDLE
//   decrypt      in   1   sampled with the key: 0 = K1..K16, 1 = K16..K1
//   abort        in   1   synchronous abandon of the current schedule
//   subkey_c     out  28  current C half
//   subkey_d     out  28  current D half
//   round_num    out  5   round being presented (1..16), 0 when not valid
//   subkey_valid out  1   subkey_c/subkey_d/round_num valid
//   subkey_ready in   1   consumer accepts the current round
//   last_round   out  1   subkey_valid && round_num == 16
//   sched_done   out  1   one-cycle pulse after round 16 is accepted
//
// Parameter AUTO_ADVANCE: 1 = advance one round per cycle while in ROUND and
// ignore subkey_ready; 0 = advance only on subkey_valid && subkey_ready.
// -----------------------------------------------------------------------------

// Permuted choice 1: this is pure wiring and contains no logic.
// Each table holds zero-based DES bit positions, in output order.
module permuted_choice_1 (
   input  logic [63:0] key_in,
   output logic [27:0] c_out,
   output logic [27:0] d_out
);

   localparam logic [5:0] PC1_C [28] = '{
      6'd56, 6'd48, 6'd40, 6'd32, 6'd24, 6'd16, 6'd8,
      6'd0,  6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17,
      6'd9,  6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26,
      6'd18, 6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35
   };

   localparam logic [5:0] PC1_D [28] = '{
      6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22, 6'd14,
      6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21,
      6'd13, 6'd5,  6'd60, 6'd52, 6'd44, 6'd36, 6'd28,
      6'd20, 6'd12, 6'd4,  6'd27, 6'd19, 6'd11, 6'd3
   };

   for (genvar g = 0; g < 28; g++) begin : g_pc1
      assign c_out[g] = key_in[PC1_C[g]];
      assign d_out[g] = key_in[PC1_D[g]];
   end

endmodule

module des_key_schedule_ctrl #(
   parameter bit AUTO_ADVANCE = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] key_in,
   input  logic        key_valid,
   output logic        key_ready,
   input  logic        decrypt,
   input  logic        abort,
   output logic [27:0] subkey_c,
   output logic [27:0] subkey_d,
   output logic [4:0]  round_num,
   output logic        subkey_valid,
   input  logic        subkey_ready,
   output logic        last_round,
   output logic        sched_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state;
   logic        dir_q;       // 1 = decrypt, so the halves rotate right
   logic [27:0] pc1_c;
   logic [27:0] pc1_d;
   logic        advance;
   logic [4:0]  next_round;
   logic        next_single; // the next round shifts by 1 instead of 2

   permuted_choice_1 u_pc1 (
      .key_in (key_in),
      .c_out  (pc1_c),
      .d_out  (pc1_d)
   );

   // Index 0 is DES bit 1. A DES left rotate therefore moves bits toward
   // index 0, and a right rotate moves them away from index 0.
   function automatic logic [27:0] rotate(input logic [27:0] x,
                                          input logic        right,
                                          input logic        single);
      logic [27:0] r;
      case ({right, single})
         2'b01:   r = {x[0],     x[27:1]};   // left by 1
         2'b00:   r = {x[1:0],   x[27:2]};   // left by 2
         2'b11:   r = {x[26:0],  x[27]};     // right by 1
         default: r = {x[25:0],  x[27:26]};  // right by 2
      endcase
      return r;
   endfunction

   assign advance    = subkey_valid && (subkey_ready || AUTO_ADVANCE);
   assign next_round = round_num + 5'd1;

   // Rounds 2..16 use the same shift amounts in both directions. Only round 1
   // differs, and that difference is taken care of when the key is loaded.
   assign next_single = (next_round == 5'd2) || (next_round == 5'd9) ||
                        (next_round == 5'd16);

   assign key_ready  = (state == IDLE);
   assign last_round = subkey_valid && (round_num == 5'd16);

   // NOTE: all state in this block is updated with non-blocking assignments.
   // Because of this, every branch reads the values from before the edge, and
   // the result does not depend on statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         dir_q        <= 1'b0;
         subkey_c     <= '0;
         subkey_d     <= '0;
         round_num    <= '0;
         subkey_valid <= 1'b0;
         sched_done   <= 1'b0;
      end else if (abort) begin
         // Abort wins over advance and over key accept. C/D are left as they
         // are because they are not valid.
         state        <= IDLE;
         round_num    <= '0;
         subkey_valid <= 1'b0;
         sched_done   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               sched_done <= 1'b0;
               if (key_valid) begin
                  // Encrypt starts at K1, which is PC-1 rotated left by 1.
                  // Decrypt starts at K16, which is PC-1 itself (total shift 28).
                  dir_q        <= decrypt;
                  subkey_c     <= decrypt ? pc1_c : rotate(pc1_c, 1'b0, 1'b1);
                  subkey_d     <= decrypt ? pc1_d : rotate(pc1_d, 1'b0, 1'b1);
                  round_num    <= 5'd1;
                  subkey_valid <= 1'b1;
                  state        <= ROUND;
               end
            end

            ROUND: begin
               if (advance) begin
                  if (round_num == 5'd16) begin
                     subkey_valid <= 1'b0;
                     round_num    <= '0;
                     sched_done   <= 1'b1;
                     state        <= DONE;
                  end else begin
                     subkey_c  <= rotate(subkey_c, dir_q, next_single);
                     subkey_d  <= rotate(subkey_d, dir_q, next_single);
                     round_num <= next_round;
                  end
               end
            end

            DONE: begin
               // This single cycle keeps a new key accept from ever
               // coinciding with sched_done.
               sched_done <= 1'b0;
               state      <= IDLE;
            end

            default: begin
               state        <= IDLE;
               round_num    <= '0;
               subkey_valid <= 1'b0;
               sched_done   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_des_key_schedule_ctrl.sv
// -----------------------------------------------------------------------------
// Directed bench for des_key_schedule_ctrl.
//
// u_dut  uses AUTO_ADVANCE = 0 and is driven by the handshake.
// u_auto uses AUTO_ADVANCE = 1 and has subkey_ready tied low.
//
// Expected C/D values come from the golden C0/D0 of key 133457799BBCDFF1,
// rotated by the cumulative DES shift table.
// -----------------------------------------------------------------------------
module tb_des_key_schedule_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] key_in;
   logic        key_valid;
   logic        decrypt;
   logic        abort;
   logic        subkey_ready;
   logic        key_ready;
   logic [27:0] subkey_c;
   logic [27:0] subkey_d;
   logic [4:0]  round_num;
   logic        subkey_valid;
   logic        last_round;
   logic        sched_done;

   logic        key_valid_a;
   logic        key_ready_a;
   logic [27:0] subkey_c_a;
   logic [27:0] subkey_d_a;
   logic [4:0]  round_num_a;
   logic        subkey_valid_a;
   logic        last_round_a;
   logic        sched_done_a;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   des_key_schedule_ctrl #(.AUTO_ADVANCE(1'b0)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .key_in       (key_in),
      .key_valid    (key_valid),
      .key_ready    (key_ready),
      .decrypt      (decrypt),
      .abort        (abort),
      .subkey_c     (subkey_c),
      .subkey_d     (subkey_d),
      .round_num    (round_num),
      .subkey_valid (subkey_valid),
      .subkey_ready (subkey_ready),
      .last_round   (last_round),
      .sched_done   (sched_done)
   );

   des_key_schedule_ctrl #(.AUTO_ADVANCE(1'b1)) u_auto (
      .clk          (clk),
      .rst          (rst),
      .key_in       (key_in),
      .key_valid    (key_valid_a),
      .key_ready    (key_ready_a),
      .decrypt      (decrypt),
      .abort        (abort),
      .subkey_c     (subkey_c_a),
      .subkey_d     (subkey_d_a),
      .round_num    (round_num_a),
      .subkey_valid (subkey_valid_a),
      .subkey_ready (1'b0),
      .last_round   (last_round_a),
      .sched_done   (sched_done_a)
   );

   // Cumulative left shift reached at rounds 1..16 of the encrypt schedule.
   int cum_shift [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};

   logic [27:0] c0;
   logic [27:0] d0;

   function automatic logic [27:0] rev28(input logic [27:0] x);
      logic [27:0] r;
      for (int i = 0; i < 28; i++) r[i] = x[27 - i];
      return r;
   endfunction

   function automatic logic [63:0] rev64(input logic [63:0] x);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[i] = x[63 - i];
      return r;
   endfunction

   // DES left rotate by n: new[i] = old[(i + n) mod 28].
   function automatic logic [27:0] rotl_n(input logic [27:0] x, input int n);
      logic [27:0] r;
      for (int i = 0; i < 28; i++) r[i] = x[(i + n) % 28];
      return r;
   endfunction

   // Decrypt round k presents encrypt round 17-k.
   function automatic int enc_round(input int k, input logic dec);
      return dec ? (17 - k) : k;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Move to 1 time unit after the next rising edge. Inputs are driven at
   // this point and outputs are sampled here too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_round(input string tag, input int k, input logic dec);
      int e;
      e = enc_round(k, dec);
      check({tag, "_round"}, 64'(round_num), 64'(k));
      check({tag, "_valid"}, 64'(subkey_valid), 64'd1);
      check({tag, "_c"}, 64'(subkey_c), 64'(rotl_n(c0, cum_shift[e - 1])));
      check({tag, "_d"}, 64'(subkey_d), 64'(rotl_n(d0, cum_shift[e - 1])));
      check({tag, "_last"}, 64'(last_round), 64'(k == 16));
      check({tag, "_done"}, 64'(sched_done), 64'd0);
   endtask

   int  hs;
   int  exp_round;
   bit  done_seen;
   bit  stalled;
   logic [27:0] prev_c;
   logic [27:0] prev_d;

   initial begin
      c0 = rev28(28'hF0CCAAF);
      d0 = rev28(28'h556678F);

      rst          = 1'b1;
      key_in       = rev64(64'h133457799BBCDFF1);
      key_valid    = 1'b0;
      key_valid_a  = 1'b0;
      decrypt      = 1'b0;
      abort        = 1'b0;
      subkey_ready = 1'b0;
      step();
      step();

      // ---------------- reset state ----------------
      check("rst_key_ready", 64'(key_ready), 64'd1);
      check("rst_valid", 64'(subkey_valid), 64'd0);
      check("rst_round", 64'(round_num), 64'd0);
      check("rst_c", 64'(subkey_c), 64'd0);
      check("rst_d", 64'(subkey_d), 64'd0);
      check("rst_done", 64'(sched_done), 64'd0);
      check("rst_last", 64'(last_round), 64'd0);
      check("rst_auto_ready", 64'(key_ready_a), 64'd1);
      rst = 1'b0;
      step();
      check("idle_hold_valid", 64'(subkey_valid), 64'd0);

      // ---------------- encrypt golden vector, ready=1 ----------------
      key_valid    = 1'b1;
      decrypt      = 1'b0;
      subkey_ready = 1'b1;
      step();                        // handshake edge; cycle 1 follows
      key_valid = 1'b0;
      check("enc_r1_c_golden", 64'(subkey_c), 64'(rev28(28'hE19955F)));
      check("enc_r1_d_golden", 64'(subkey_d), 64'(rev28(28'hAACCF1E)));
      check("enc_key_ready_busy", 64'(key_ready), 64'd0);
      for (int cyc = 1; cyc <= 16; cyc++) begin
         if (cyc == 2) begin
            check("enc_r2_c_golden", 64'(subkey_c), 64'(rev28(28'hC332ABF)));
            check("enc_r2_d_golden", 64'(subkey_d), 64'(rev28(28'h5599E3D)));
         end
         if (cyc == 16) begin
            check("enc_r16_c_golden", 64'(subkey_c), 64'(rev28(28'hF0CCAAF)));
            check("enc_r16_d_golden", 64'(subkey_d), 64'(rev28(28'h556678F)));
         end
         check_round("enc", cyc, 1'b0);
         step();
      end
      // cycle 17: DONE
      check("enc_done_pulse", 64'(sched_done), 64'd1);
      check("enc_done_valid", 64'(subkey_valid), 64'd0);
      check("enc_done_round", 64'(round_num), 64'd0);
      check("enc_done_key_ready", 64'(key_ready), 64'd0);
      step();
      check("enc_idle_done_low", 64'(sched_done), 64'd0);
      check("enc_idle_key_ready", 64'(key_ready), 64'd1);

      // ---------------- decrypt same key ----------------
      key_valid = 1'b1;
      decrypt   = 1'b1;
      step();
      key_valid = 1'b0;
      decrypt   = 1'b0;              // the direction must stay latched
      check("dec_r1_c_golden", 64'(subkey_c), 64'(rev28(28'hF0CCAAF)));
      check("dec_r1_d_golden", 64'(subkey_d), 64'(rev28(28'h556678F)));
      for (int cyc = 1; cyc <= 16; cyc++) begin
         if (cyc == 16) begin
            check("dec_r16_c_golden", 64'(subkey_c), 64'(rev28(28'hE19955F)));
            check("dec_r16_d_golden", 64'(subkey_d), 64'(rev28(28'hAACCF1E)));
         end
         check_round("dec", cyc, 1'b1);
         step();
      end
      check("dec_done_pulse", 64'(sched_done), 64'd1);
      step();

      // ---------------- backpressure ----------------
      key_valid    = 1'b1;
      subkey_ready = 1'b0;
      step();
      key_valid = 1'b0;
      hs        = 0;
      exp_round = 1;
      done_seen = 1'b0;
      stalled   = 1'b0;
      prev_c    = '0;
      prev_d    = '0;
      for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
         if (hs == 16) begin
            check("bp_done_pulse", 64'(sched_done), 64'd1);
            check("bp_done_valid", 64'(subkey_valid), 64'd0);
            done_seen = 1'b1;
         end else begin
            check_round("bp", exp_round, 1'b0);
            if (stalled) begin
               check("bp_stall_c", 64'(subkey_c), 64'(prev_c));
               check("bp_stall_d", 64'(subkey_d), 64'(prev_d));
            end
            prev_c       = subkey_c;
            prev_d       = subkey_d;
            subkey_ready = 1'($urandom_range(0, 1));
            stalled      = !subkey_ready;
            if (subkey_ready) begin
               hs++;
               if (exp_round < 16) exp_round++;
            end
            step();
         end
      end
      check("bp_finished", 64'(done_seen), 64'd1);
      check("bp_handshakes", 64'(hs), 64'd16);
      step();

      // ---------------- abort at round 7 ----------------
      subkey_ready = 1'b1;
      key_valid    = 1'b1;
      step();
      key_valid = 1'b0;
      for (int cyc = 1; cyc < 7; cyc++) step();
      check("ab_at_round7", 64'(round_num), 64'd7);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("ab_valid", 64'(subkey_valid), 64'd0);
      check("ab_round", 64'(round_num), 64'd0);
      check("ab_key_ready", 64'(key_ready), 64'd1);
      check("ab_no_done", 64'(sched_done), 64'd0);
      step();
      check("ab_no_done_later", 64'(sched_done), 64'd0);

      // An abort together with key_valid in IDLE means the key is not accepted.
      abort     = 1'b1;
      key_valid = 1'b1;
      step();
      abort     = 1'b0;
      key_valid = 1'b0;
      check("ab_key_rejected", 64'(subkey_valid), 64'd0);
      check("ab_key_rejected_ready", 64'(key_ready), 64'd1);

      // A new key then starts cleanly at round 1.
      key_valid = 1'b1;
      step();
      key_valid = 1'b0;
      check_round("ab_restart", 1, 1'b0);

      // ---------------- rst at round 12 ----------------
      for (int cyc = 1; cyc < 12; cyc++) step();
      check("rs_at_round12", 64'(round_num), 64'd12);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rs_valid", 64'(subkey_valid), 64'd0);
      check("rs_round", 64'(round_num), 64'd0);
      check("rs_c", 64'(subkey_c), 64'd0);
      check("rs_d", 64'(subkey_d), 64'd0);
      check("rs_done", 64'(sched_done), 64'd0);
      check("rs_key_ready", 64'(key_ready), 64'd1);
      step();
      check("rs_no_done_later", 64'(sched_done), 64'd0);
      key_valid = 1'b1;
      step();
      key_valid = 1'b0;
      check_round("rs_restart", 1, 1'b0);
      abort = 1'b1;
      step();
      abort = 1'b0;

      // ---------------- AUTO_ADVANCE, key_valid held high ----------------
      decrypt     = 1'b0;
      key_valid_a = 1'b1;
      step();
      for (int cyc = 1; cyc <= 16; cyc++) begin
         check("auto_round", 64'(round_num_a), 64'(cyc));
         check("auto_valid", 64'(subkey_valid_a), 64'd1);
         check("auto_c", 64'(subkey_c_a), 64'(rotl_n(c0, cum_shift[cyc - 1])));
         check("auto_last", 64'(last_round_a), 64'(cyc == 16));
         check("auto_key_ready", 64'(key_ready_a), 64'd0);
         step();
      end
      check("auto_done_pulse", 64'(sched_done_a), 64'd1);
      check("auto_done_key_ready", 64'(key_ready_a), 64'd0);
      check("auto_done_valid", 64'(subkey_valid_a), 64'd0);
      step();
      check("auto_idle_key_ready", 64'(key_ready_a), 64'd1);
      check("auto_idle_valid", 64'(subkey_valid_a), 64'd0);
      check("auto_idle_done_low", 64'(sched_done_a), 64'd0);
      step();
      check("auto_reaccept_round", 64'(round_num_a), 64'd1);
      key_valid_a = 1'b0;
      abort       = 1'b1;
      step();
      abort = 1'b0;
      check("auto_abort_valid", 64'(subkey_valid_a), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
